// File: rtl/traffic_pkg.sv
// Shared lamp encodings, mirror states and error codes for the traffic-light
// controller and its monitor.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    RED     = 2'd1,
    GREEN   = 2'd2,
    YELLOW  = 2'd3
  } lamp_state_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_CONFLICT   = 3'd1,
    ERR_INVALID    = 3'd2,
    ERR_TRANSITION = 3'd3,
    ERR_YEL_SHORT  = 3'd4,
    ERR_YEL_LONG   = 3'd5
  } err_code_e;

  // Holding the same phase is always legal; otherwise only the G->Y->R->G ring.
  function automatic logic is_legal(input lamp_state_e from_st, input lamp_state_e to_st);
    return (from_st == to_st) ||
           (from_st == GREEN  && to_st == YELLOW) ||
           (from_st == YELLOW && to_st == RED)    ||
           (from_st == RED    && to_st == GREEN);
  endfunction

endpackage

// File: rtl/traffic_monitor_mirror.sv
// street_mirror: follows one street's lamp phase and times its yellow dwell in ticks.
// Flags are combinational on the current lamp input so the top can latch them in one cycle.
module street_mirror
  import traffic_pkg::*;
#(
  parameter int YELLOW_MIN_S = 2,
  parameter int YELLOW_MAX_S = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  lamp_i,
  input  logic        tick_i,
  output lamp_state_e state_o,
  output logic        illegal_o,
  output logic        invalid_o,
  output logic        yel_short_o,
  output logic        yel_long_o
);

  localparam int DW = $clog2(YELLOW_MAX_S + 2);
  localparam logic [DW-1:0] DWELL_SAT = DW'(YELLOW_MAX_S + 1);
  localparam logic [DW-1:0] DWELL_MIN = DW'(YELLOW_MIN_S);

  lamp_state_e     state_q, state_d;
  logic [DW-1:0]   dwell_q;
  logic            lamp_valid;

  // An invalid code leaves state_d at the held state.
  always_comb begin
    lamp_valid = 1'b1;
    state_d    = state_q;
    case (lamp_i)
      LAMP_RED:    state_d = RED;
      LAMP_YELLOW: state_d = YELLOW;
      LAMP_GREEN:  state_d = GREEN;
      default:     lamp_valid = 1'b0;
    endcase
  end

  assign state_o     = state_q;
  assign invalid_o   = !lamp_valid;
  assign illegal_o   = lamp_valid && (state_q != UNKNOWN) && !is_legal(state_q, state_d);
  assign yel_short_o = lamp_valid && (state_q == YELLOW) && (state_d == RED) && (dwell_q < DWELL_MIN);
  assign yel_long_o  = (state_q == YELLOW) && (dwell_q == DWELL_SAT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= UNKNOWN;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == YELLOW && state_q != YELLOW) begin
        dwell_q <= '0;
      end else if (state_q == YELLOW && tick_i && dwell_q != DWELL_SAT) begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_monitor.sv
// traffic_monitor: passive safety/sequencing checker on both street lamp buses.
// Optional TRAFFIC_MON_STATS_EN adds cycles_o, a count of street-1 RED->GREEN steps.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int YELLOW_MIN_S = 2,
  parameter int YELLOW_MAX_S = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  street1_i,
  input  logic [2:0]  street2_i,
  input  logic        clr_i,
  output logic        err_o,
  output logic [2:0]  err_code_o,
  output logic        tick_o
`ifdef TRAFFIC_MON_STATS_EN
  ,
  output logic [15:0] cycles_o
`endif
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_FREQ - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;
  logic          err_q;
  err_code_e     err_code_q, err_now;

  lamp_state_e   st1, st2;
  logic          ill1, ill2, inv1, inv2, ys1, ys2, yl1, yl2;
  logic          conflict;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

  street_mirror #(.YELLOW_MIN_S(YELLOW_MIN_S), .YELLOW_MAX_S(YELLOW_MAX_S)) u_mirror1 (
    .clk_i(clk_i), .rst_i(rst_i), .lamp_i(street1_i), .tick_i(tick_q),
    .state_o(st1), .illegal_o(ill1), .invalid_o(inv1), .yel_short_o(ys1), .yel_long_o(yl1)
  );

  street_mirror #(.YELLOW_MIN_S(YELLOW_MIN_S), .YELLOW_MAX_S(YELLOW_MAX_S)) u_mirror2 (
    .clk_i(clk_i), .rst_i(rst_i), .lamp_i(street2_i), .tick_i(tick_q),
    .state_o(st2), .illegal_o(ill2), .invalid_o(inv2), .yel_short_o(ys2), .yel_long_o(yl2)
  );

  assign conflict = !inv1 && !inv2 && (street1_i != LAMP_RED) && (street2_i != LAMP_RED);

  // Lowest code wins when several checks fire, on either street.
  always_comb begin
    err_now = ERR_NONE;
    if (conflict)          err_now = ERR_CONFLICT;
    else if (inv1 || inv2) err_now = ERR_INVALID;
    else if (ill1 || ill2) err_now = ERR_TRANSITION;
    else if (ys1 || ys2)   err_now = ERR_YEL_SHORT;
    else if (yl1 || yl2)   err_now = ERR_YEL_LONG;
  end

  // A violation in the clear cycle re-latches instead of clearing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (err_now != ERR_NONE && (!err_q || clr_i)) begin
      err_q      <= 1'b1;
      err_code_q <= err_now;
    end else if (clr_i) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end
  end

  assign err_o      = err_q;
  assign err_code_o = err_code_q;

`ifdef TRAFFIC_MON_STATS_EN
  logic [15:0] cycles_q;
  logic [1:0]  unused_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycles_q <= '0;
    end else if (st1 == RED && street1_i == LAMP_GREEN) begin
      cycles_q <= cycles_q + 16'd1;
    end
  end

  assign cycles_o     = cycles_q;
  assign unused_state = st2;
`else
  logic [3:0] unused_state;
  assign unused_state = {st1, st2};
`endif

endmodule
